pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter DBITS, default 32, PC/data width in bits.
REQ-002 Parameter INSTSIZE, default 4, instruction size in bytes (PC increment).
REQ-003 Parameter STARTPC, default 32'h60, PC value loaded on reset.
REQ-004 Parameter TRAPVEC, default 32'h40, PC value loaded on trap.
REQ-005 Parameter RASDEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-006 CLK  input  1  clock; all state updates on rising edge.
REQ-007 RESET  input  1  reset; synchronous, active-high.
REQ-008 STALL  input  1  hold PC when no redirect is active.
REQ-009 JMP  input  1  redirect to JMPTGT.
REQ-010 JMPTGT  input  DBITS  jump/branch target address.
REQ-011 CALL  input  1  push PCINCOUT onto RAS (qualified by JMP).
REQ-012 RETPOP  input  1  pop RAS top into PC.
REQ-013 TRAP  input  1  redirect to TRAPVEC, capture PCOUT into EPC.
REQ-014 ERET  input  1  redirect to EPC (return from trap).
REQ-015 PCOUT  output  DBITS  current PC.
REQ-016 PCINCOUT  output  DBITS  PCOUT + INSTSIZE, combinational.
REQ-017 EPCOUT  output  DBITS  saved exception PC.
REQ-018 RASEMPTY  output  1  RAS holds 0 entries.
REQ-019 RASFULL  output  1  RAS holds RASDEPTH entries.

Function
REQ-020 Next PC priority, highest first: RESET -> STARTPC; TRAP -> TRAPVEC; ERET -> EPC; JMP -> JMPTGT; RETPOP with RAS non-empty -> RAS top; !STALL -> PCINCOUT; else hold.
REQ-021 Redirects (TRAP, ERET, JMP, valid RETPOP) override STALL.
REQ-022 JMP loads JMPTGT exactly, with no INSTSIZE added.
REQ-023 PCINCOUT arithmetic modulo 2^DBITS; all-ones region wraps to low addresses without error.
REQ-024 TRAP writes EPC <= PCOUT in the same edge as the PC redirect; EPC otherwise holds.
REQ-025 TRAP and ERET in the same cycle: TRAP wins and EPC is updated.
REQ-026 Push occurs only when CALL && JMP are both high and no TRAP/ERET is active; pushed value = PCINCOUT.
REQ-027 Pop occurs only when RETPOP is high, RAS is non-empty, and no TRAP/ERET/JMP is active.
REQ-028 RETPOP on an empty RAS is a no-op pop; PC follows the STALL/increment rule.
REQ-029 Push when full overwrites the oldest entry (circular); count saturates at RASDEPTH and RASFULL stays 1.
REQ-030 Push and pop never qualify in the same cycle because JMP masks the pop.
REQ-031 RASEMPTY/RASFULL are registered state, valid the cycle after the push/pop edge.
REQ-032 All outputs except PCINCOUT are registered; a redirect is visible on PCOUT one cycle after assertion.

Reset
REQ-033 On RESET: PCOUT=STARTPC, EPCOUT=0, RAS count=0, RASEMPTY=1, RASFULL=0; RAS entry contents don't-care.
REQ-034 RESET overrides every other input in the same cycle, including mid-trap and mid-push.

Configuration
REQ-035 Macro PC_GEN_RAS_EN defined: RAS logic, CALL/RETPOP behaviour and RASEMPTY/RASFULL as specified.
REQ-036 PC_GEN_RAS_EN undefined: no RAS storage; CALL and RETPOP ignored; RASEMPTY tied 1, RASFULL tied 0; all other behaviour unchanged.

Verification
REQ-037 Reset, then 3 cycles with STALL=0 -> PCOUT 0x60, 0x64, 0x68, 0x6C; STALL=1 for 2 cycles -> PCOUT holds 0x6C.
REQ-038 STALL=1 with JMP=1, JMPTGT=0x200 -> PCOUT=0x200 next cycle.
REQ-039 At PCOUT=0x100: TRAP=1 and ERET=1 together -> PCOUT=0x40, EPCOUT=0x100; later ERET=1 alone -> PCOUT=0x100.
REQ-040 With RAS enabled: CALL+JMP at PCOUT=0x80 to 0x300 -> PCOUT=0x300, RASEMPTY=0; RETPOP -> PCOUT=0x84, RASEMPTY=1.
REQ-041 With RAS enabled: 5 pushes with RASDEPTH=4 -> RASFULL=1; 4 pops return the newest 4 addresses in LIFO order; a 5th RETPOP -> PC increments normally.
REQ-042 PCOUT=32'hFFFFFFFC, STALL=0 -> PCOUT=0x0; RESET mid-sequence -> PCOUT=0x60 and RASEMPTY=1 next cycle.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: program counter generator with trap/return support and an
// optional return-address stack (RAS) enabled by the macro PC_GEN_RAS_EN.
//
// Next-PC priority (highest first): RESET, TRAP, ERET, JMP, RETPOP with a
// non-empty RAS, increment when not stalled, otherwise hold. Every redirect
// overrides STALL. PCINCOUT is the only combinational output.
//
// With PC_GEN_RAS_EN undefined there is no RAS storage: CALL and RETPOP are
// ignored, RASEMPTY reads 1 and RASFULL reads 0.
module pc_gen #(
    parameter int                DBITS    = 32,
    parameter int                INSTSIZE = 4,
    parameter logic [DBITS-1:0]  STARTPC  = 'h60,
    parameter logic [DBITS-1:0]  TRAPVEC  = 'h40,
    parameter int                RASDEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL,
    input  logic             JMP,
    input  logic [DBITS-1:0] JMPTGT,
    input  logic             CALL,
    input  logic             RETPOP,
    input  logic             TRAP,
    input  logic             ERET,
    output logic [DBITS-1:0] PCOUT,
    output logic [DBITS-1:0] PCINCOUT,
    output logic [DBITS-1:0] EPCOUT,
    output logic             RASEMPTY,
    output logic             RASFULL
);

    logic [DBITS-1:0] pc_q;
    logic [DBITS-1:0] epc_q;
    logic [DBITS-1:0] pc_inc;
    logic [DBITS-1:0] pc_next;

    // Stack interface seen by the next-PC mux.
    logic             ras_pop;
    logic [DBITS-1:0] ras_top;
    logic             ras_empty;
    logic             ras_full;

    // Increment wraps naturally modulo 2^DBITS.
    assign pc_inc = pc_q + DBITS'(INSTSIZE);

`ifdef PC_GEN_RAS_EN
    localparam int PTRW = (RASDEPTH > 1) ? $clog2(RASDEPTH) : 1;
    localparam logic [PTRW-1:0] PTR_ONE   = PTRW'(1);
    localparam logic [PTRW:0]   CNT_DEPTH = (PTRW+1)'(RASDEPTH);

    logic [DBITS-1:0] ras_mem [RASDEPTH];
    logic [PTRW-1:0]  ras_ptr;   // next slot to write; top is ras_ptr-1
    logic [PTRW:0]    ras_cnt;   // live entries, saturates at RASDEPTH
    logic             ras_push;

    // A push rides on a call jump unless a trap/eret takes the cycle; a pop
    // needs an entry and yields to any higher-priority redirect, so the two
    // can never coincide (JMP masks the pop).
    assign ras_push  = CALL && JMP && !TRAP && !ERET;
    assign ras_pop   = RETPOP && !ras_empty && !TRAP && !ERET && !JMP;
    assign ras_top   = ras_mem[ras_ptr - PTR_ONE];
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_DEPTH);

    // Stack storage: circular, so a push when full overwrites the oldest.
    always_ff @(posedge CLK) begin
        if (ras_push) begin
            ras_mem[ras_ptr] <= pc_inc;
        end
    end

    // Stack pointer and occupancy count.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (ras_push) begin
            ras_ptr <= ras_ptr + PTR_ONE;
            if (!ras_full) begin
                ras_cnt <= ras_cnt + 1'b1;
            end
        end else if (ras_pop) begin
            ras_ptr <= ras_ptr - PTR_ONE;
            ras_cnt <= ras_cnt - 1'b1;
        end
    end
`else
    logic unused_ras_inputs;

    assign unused_ras_inputs = &{1'b0, CALL, RETPOP};
    assign ras_pop   = 1'b0;
    assign ras_top   = '0;
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
`endif

    // Next-PC selection in priority order; reset is applied in the register.
    always_comb begin
        pc_next = pc_q;
        if (TRAP) begin
            pc_next = TRAPVEC;
        end else if (ERET) begin
            pc_next = epc_q;
        end else if (JMP) begin
            pc_next = JMPTGT;
        end else if (ras_pop) begin
            pc_next = ras_top;
        end else if (!STALL) begin
            pc_next = pc_inc;
        end
    end

    // PC and exception-PC registers; EPC captures the trapping PC.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q  <= STARTPC;
            epc_q <= '0;
        end else begin
            pc_q <= pc_next;
            if (TRAP) begin
                epc_q <= pc_q;
            end
        end
    end

    assign PCOUT    = pc_q;
    assign PCINCOUT = pc_inc;
    assign EPCOUT   = epc_q;
    assign RASEMPTY = ras_empty;
    assign RASFULL  = ras_full;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with hand-computed expected values (defaults:
// DBITS=32, INSTSIZE=4, STARTPC=0x60, TRAPVEC=0x40, RASDEPTH=4).
module tb_pc_gen;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        STALL = 1'b0;
    logic        JMP = 1'b0;
    logic [31:0] JMPTGT = '0;
    logic        CALL = 1'b0;
    logic        RETPOP = 1'b0;
    logic        TRAP = 1'b0;
    logic        ERET = 1'b0;
    logic [31:0] PCOUT;
    logic [31:0] PCINCOUT;
    logic [31:0] EPCOUT;
    logic        RASEMPTY;
    logic        RASFULL;

    int total = 0;
    int bad   = 0;

    pc_gen dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .STALL    (STALL),
        .JMP      (JMP),
        .JMPTGT   (JMPTGT),
        .CALL     (CALL),
        .RETPOP   (RETPOP),
        .TRAP     (TRAP),
        .ERET     (ERET),
        .PCOUT    (PCOUT),
        .PCINCOUT (PCINCOUT),
        .EPCOUT   (EPCOUT),
        .RASEMPTY (RASEMPTY),
        .RASFULL  (RASFULL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it before sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        STALL = 1'b1; JMP = 1'b0; CALL = 1'b0; RETPOP = 1'b0;
        TRAP = 1'b0;  ERET = 1'b0; RESET = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] tgt);
        JMP = 1'b1; JMPTGT = tgt;
        tick();
        JMP = 1'b0;
    endtask

`ifdef PC_GEN_RAS_EN
    // Call from the current PC to tgt; the return address is pushed.
    task automatic call_to(input logic [31:0] tgt);
        CALL = 1'b1; JMP = 1'b1; JMPTGT = tgt;
        tick();
        CALL = 1'b0; JMP = 1'b0;
    endtask

    task automatic ret_pop();
        RETPOP = 1'b1;
        tick();
        RETPOP = 1'b0;
    endtask
`endif

    initial begin
        // Reset state
        #2;
        RESET = 1'b1;
        tick();
        check("rst_pc", PCOUT, 32'h60);
        check("rst_pcinc", PCINCOUT, 32'h64);
        check("rst_epc", EPCOUT, 32'h0);
        check("rst_empty", {31'b0, RASEMPTY}, 32'h1);
        check("rst_full", {31'b0, RASFULL}, 32'h0);
        RESET = 1'b0;

        // Sequential increment, then stall hold
        STALL = 1'b0;
        tick(); check("inc1", PCOUT, 32'h64);
        tick(); check("inc2", PCOUT, 32'h68);
        tick(); check("inc3", PCOUT, 32'h6C);
        STALL = 1'b1;
        tick(); check("stall1", PCOUT, 32'h6C);
        tick(); check("stall2", PCOUT, 32'h6C);

        // Jump overrides stall and loads the target exactly
        jump_to(32'h200);
        check("jmp_stall", PCOUT, 32'h200);

        // Trap and eret together: trap wins, EPC captures current PC
        jump_to(32'h100);
        check("at_100", PCOUT, 32'h100);
        TRAP = 1'b1; ERET = 1'b1;
        tick();
        TRAP = 1'b0; ERET = 1'b0;
        check("trap_pc", PCOUT, 32'h40);
        check("trap_epc", EPCOUT, 32'h100);
        STALL = 1'b0;
        tick();
        check("post_trap_inc", PCOUT, 32'h44);
        check("epc_hold", EPCOUT, 32'h100);
        STALL = 1'b1;
        ERET = 1'b1;
        tick();
        ERET = 1'b0;
        check("eret_pc", PCOUT, 32'h100);

        // Wrap at the top of the address space
        jump_to(32'hFFFF_FFFC);
        check("top_pcinc", PCINCOUT, 32'h0);
        STALL = 1'b0;
        tick();
        check("wrap_pc", PCOUT, 32'h0);

        // Trap while stalled at address zero: EPC updates to 0
        STALL = 1'b1; TRAP = 1'b1;
        tick();
        TRAP = 1'b0;
        check("trap2_pc", PCOUT, 32'h40);
        check("trap2_epc", EPCOUT, 32'h0);

        jump_to(32'h80);
`ifdef PC_GEN_RAS_EN
        // Single call/return
        call_to(32'h300);
        check("call_pc", PCOUT, 32'h300);
        check("call_empty", {31'b0, RASEMPTY}, 32'h0);
        ret_pop();
        check("ret_pc", PCOUT, 32'h84);
        check("ret_empty", {31'b0, RASEMPTY}, 32'h1);

        // Five pushes into a four-entry stack
        call_to(32'h400);  // pushes 0x88
        call_to(32'h500);  // pushes 0x404
        call_to(32'h600);  // pushes 0x504
        check("full_after3", {31'b0, RASFULL}, 32'h0);
        call_to(32'h700);  // pushes 0x604
        check("full_after4", {31'b0, RASFULL}, 32'h1);
        call_to(32'h800);  // pushes 0x704, evicts 0x88
        check("full_after5", {31'b0, RASFULL}, 32'h1);
        check("pc_800", PCOUT, 32'h800);

        // LIFO pops of the newest four
        ret_pop(); check("pop1", PCOUT, 32'h704);
        check("not_full", {31'b0, RASFULL}, 32'h0);
        ret_pop(); check("pop2", PCOUT, 32'h604);
        ret_pop(); check("pop3", PCOUT, 32'h504);
        ret_pop(); check("pop4", PCOUT, 32'h404);
        check("pop_empty", {31'b0, RASEMPTY}, 32'h1);

        // Pop on empty stack: plain increment
        STALL = 1'b0;
        ret_pop();
        check("pop_empty_inc", PCOUT, 32'h408);
        STALL = 1'b1;

        // Reset mid-push and mid-trap
        call_to(32'h900);
        check("pre_rst_empty", {31'b0, RASEMPTY}, 32'h0);
        RESET = 1'b1; CALL = 1'b1; JMP = 1'b1; TRAP = 1'b1; JMPTGT = 32'hA00;
        tick();
        idle_inputs();
`else
        // Without a stack CALL/RETPOP have no effect beyond the jump
        CALL = 1'b1; JMP = 1'b1; JMPTGT = 32'h300;
        tick();
        CALL = 1'b0; JMP = 1'b0;
        check("call_pc", PCOUT, 32'h300);
        check("call_empty", {31'b0, RASEMPTY}, 32'h1);
        RETPOP = 1'b1;
        tick();
        RETPOP = 1'b0;
        check("ret_ignored", PCOUT, 32'h300);
        check("ret_full", {31'b0, RASFULL}, 32'h0);
        STALL = 1'b0; RETPOP = 1'b1;
        tick();
        RETPOP = 1'b0; STALL = 1'b1;
        check("ret_inc", PCOUT, 32'h304);

        // Reset mid-push and mid-trap
        RESET = 1'b1; CALL = 1'b1; JMP = 1'b1; TRAP = 1'b1; JMPTGT = 32'hA00;
        tick();
        idle_inputs();
`endif
        check("mid_rst_pc", PCOUT, 32'h60);
        check("mid_rst_epc", EPCOUT, 32'h0);
        check("mid_rst_empty", {31'b0, RASEMPTY}, 32'h1);
        check("mid_rst_full", {31'b0, RASFULL}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
